pipe_hazard_ctrl: RTL

- Central stall/bubble controller for the 5-stage pipeline registers (regF, regD, regE, regM, regW).
- Detects load-use hazards, branch/jump redirects, I-fetch not-ready and D-side memory waits.
- Sequences the D-cache request handshake for the instruction held in regM.
- Drives the per-stage `*_stall` / `*_bubble` controls consumed by the pipeline register blocks.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_if.sv | 10 +
 rtl/pipe_dmem_seq.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its D-side sequencer.
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_e;

  typedef struct packed {
    logic stall;
    logic bubble;
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// D-cache handshake bundle between the hazard controller and the D-side sequencer.
interface pipe_hazard_ctrl_if;
  logic mem_req;
  logic ack;
  logic req;
  logic mem_wait;

  modport master (input mem_req, input ack, output req, output mem_wait);
  modport slave  (output mem_req, output ack, input req, input mem_wait);
endinterface

// File: rtl/pipe_dmem_seq.sv
// IDLE/WAIT sequencer for the D-cache request of the instruction held in regM.
module pipe_dmem_seq
  import pipe_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.master   dif
);

  dmem_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Request is gated by reset so an in-flight op is dropped immediately.
  always_comb begin
    state_d      = state_q;
    dif.req      = 1'b0;
    dif.mem_wait = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (dif.mem_req) begin
            dif.req      = 1'b1;
            dif.mem_wait = 1'b1;
            state_d      = WAIT;
          end
        end
        WAIT: begin
          dif.req = 1'b1;
          if (dif.ack) state_d      = IDLE;
          else         dif.mem_wait = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline registers.
// Optional perf counters built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = pipe_ctrl_pkg::REG_AW,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] decode_i_rs1,
  input  logic [REG_AW-1:0] decode_i_rs2,
  input  logic              decode_i_rs1_ren,
  input  logic              decode_i_rs2_ren,
  input  logic [REG_AW-1:0] regE_i_rd,
  input  logic              regE_i_reg_wen,
  input  logic              regE_i_is_load,
  input  logic              execute_i_redirect,
  input  logic              fetch_i_valid,
  input  logic              regM_i_mem_req,
  input  logic              dmem_i_ack,
  output logic              dmem_o_req,
  output logic              regF_o_stall,
  output logic              regD_o_stall,
  output logic              regD_o_bubble,
  output logic              regE_o_stall,
  output logic              regE_o_bubble,
  output logic              regM_o_stall,
  output logic              regM_o_bubble,
  output logic              regW_o_bubble
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_o_mem_stall_cnt,
  output logic [PERF_W-1:0] perf_o_lu_stall_cnt,
  output logic [PERF_W-1:0] perf_o_redirect_cnt
`endif
);

  pipe_hazard_ctrl_if dif ();

  assign dif.mem_req = regM_i_mem_req;
  assign dif.ack     = dmem_i_ack;
  assign dmem_o_req  = dif.req;

  pipe_dmem_seq u_dmem_seq (
    .clk (clk),
    .rst (rst),
    .dif (dif.master)
  );

  logic        hazard_lu;
  logic        lu_apply;
  logic        redir_apply;
  logic        f_stall;
  logic        w_bubble;
  stage_ctrl_t d_c, e_c, m_c;

  assign hazard_lu = regE_i_is_load & regE_i_reg_wen & (regE_i_rd != '0) &
                     ((decode_i_rs1_ren & (decode_i_rs1 == regE_i_rd)) |
                      (decode_i_rs2_ren & (decode_i_rs2 == regE_i_rd)));

  // A memory wait freezes E, so redirect/hazard are simply re-evaluated once it ends.
  always_comb begin
    f_stall     = 1'b0;
    w_bubble    = 1'b0;
    d_c         = '0;
    e_c         = '0;
    m_c         = '0;
    lu_apply    = 1'b0;
    redir_apply = 1'b0;
    if (!rst) begin
      d_c.bubble = 1'b1;
      e_c.bubble = 1'b1;
      m_c.bubble = 1'b1;
      w_bubble   = 1'b1;
    end else if (dif.mem_wait) begin
      f_stall   = 1'b1;
      d_c.stall = 1'b1;
      e_c.stall = 1'b1;
      m_c.stall = 1'b1;
      w_bubble  = 1'b1;
    end else if (execute_i_redirect) begin
      d_c.bubble  = 1'b1;
      e_c.bubble  = 1'b1;
      redir_apply = 1'b1;
    end else if (hazard_lu) begin
      f_stall    = 1'b1;
      d_c.stall  = 1'b1;
      e_c.bubble = 1'b1;
      lu_apply   = 1'b1;
    end else if (!fetch_i_valid) begin
      f_stall    = 1'b1;
      d_c.bubble = 1'b1;
    end
  end

  assign regF_o_stall  = f_stall;
  assign regD_o_stall  = d_c.stall;
  assign regD_o_bubble = d_c.bubble;
  assign regE_o_stall  = e_c.stall;
  assign regE_o_bubble = e_c.bubble;
  assign regM_o_stall  = m_c.stall;
  assign regM_o_bubble = m_c.bubble;
  assign regW_o_bubble = w_bubble;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v,
                                                input logic             en);
    logic [PERF_W-1:0] one;
    one = {{(PERF_W-1){1'b0}}, 1'b1};
    return (en && !(&v)) ? v + one : v;
  endfunction

  logic [PERF_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [PERF_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [PERF_W-1:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    mem_cnt_d   = sat_inc(mem_cnt_q, rst & dif.mem_wait);
    lu_cnt_d    = sat_inc(lu_cnt_q, lu_apply);
    redir_cnt_d = sat_inc(redir_cnt_q, redir_apply);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_cnt_q   <= '0;
      lu_cnt_q    <= '0;
      redir_cnt_q <= '0;
    end else begin
      mem_cnt_q   <= mem_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign perf_o_mem_stall_cnt = mem_cnt_q;
  assign perf_o_lu_stall_cnt  = lu_cnt_q;
  assign perf_o_redirect_cnt  = redir_cnt_q;
`endif

endmodule
